// File: rtl/stage_id.sv
// Instruction Decode stage: decodes the fetched word, reads the write-first register
// file, detects load-use hazards and registers the result into the ID/EX register.
module stage_id #(
  parameter logic [31:0] RESET_PC4 = 32'd4
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] IFout_PC4,
  input  logic [31:0] IFout_Inst,
  input  logic        MEM_PCSrc,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_Rd,
  input  logic [31:0] WB_Data,
  output logic        IF_EN,
  output logic        IDout_Valid,
  output logic [31:0] IDout_PC4,
  output logic [31:0] IDout_A,
  output logic [31:0] IDout_B,
  output logic [31:0] IDout_Imm,
  output logic [31:0] IDout_Jtarg,
  output logic [4:0]  IDout_Rs,
  output logic [4:0]  IDout_Rt,
  output logic [4:0]  IDout_Rd,
  output logic        IDout_RegWrite,
  output logic        IDout_MemtoReg,
  output logic        IDout_MemRead,
  output logic        IDout_MemWrite,
  output logic        IDout_Branch,
  output logic        IDout_Jump,
  output logic        IDout_ALUSrc,
  output logic        IDout_RegDst,
  output logic [2:0]  IDout_ALUCtrl
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [31:0] r_regs [32];

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic        w_regwrite, w_memtoreg, w_memread, w_memwrite;
  logic        w_branch, w_jump, w_alusrc, w_regdst;
  logic [2:0]  w_aluctrl;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_uses_rt;
  logic        w_stall;
  logic        w_bubble;

  assign w_op    = IFout_Inst[31:26];
  assign w_funct = IFout_Inst[5:0];
  assign w_rs    = IFout_Inst[25:21];
  assign w_rt    = IFout_Inst[20:16];

  // Main decoder: opcode/funct to control bits; anything unrecognised is a NOP
  always_comb begin
    w_regwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_branch   = 1'b0;
    w_jump     = 1'b0;
    w_alusrc   = 1'b0;
    w_regdst   = 1'b0;
    w_aluctrl  = ALU_ADD;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          6'h20:   begin w_regwrite = 1'b1; w_regdst = 1'b1; w_aluctrl = ALU_ADD; end
          6'h22:   begin w_regwrite = 1'b1; w_regdst = 1'b1; w_aluctrl = ALU_SUB; end
          6'h24:   begin w_regwrite = 1'b1; w_regdst = 1'b1; w_aluctrl = ALU_AND; end
          6'h25:   begin w_regwrite = 1'b1; w_regdst = 1'b1; w_aluctrl = ALU_OR;  end
          6'h2A:   begin w_regwrite = 1'b1; w_regdst = 1'b1; w_aluctrl = ALU_SLT; end
          default: w_aluctrl = ALU_ADD;
        endcase
      end
      OP_LW:   begin w_regwrite = 1'b1; w_memtoreg = 1'b1; w_memread = 1'b1; w_alusrc = 1'b1; end
      OP_SW:   begin w_memwrite = 1'b1; w_alusrc = 1'b1; end
      OP_BEQ:  begin w_branch = 1'b1; w_aluctrl = ALU_SUB; end
      OP_ADDI: begin w_regwrite = 1'b1; w_alusrc = 1'b1; end
      OP_J:    w_jump = 1'b1;
      default: w_aluctrl = ALU_ADD;
    endcase
  end

  // Write-first register read so a WB write lands in the same cycle's operands
  always_comb begin
    if (w_rs == 5'd0) begin
      w_a = 32'd0;
    end else if (WB_RegWrite && (WB_Rd == w_rs)) begin
      w_a = WB_Data;
    end else begin
      w_a = r_regs[w_rs];
    end
    if (w_rt == 5'd0) begin
      w_b = 32'd0;
    end else if (WB_RegWrite && (WB_Rd == w_rt)) begin
      w_b = WB_Data;
    end else begin
      w_b = r_regs[w_rt];
    end
  end

  // rt is only a source for R-type, sw and beq; addi/lw write it instead
  assign w_uses_rt = (w_op == OP_RTYPE) || (w_op == OP_SW) || (w_op == OP_BEQ);
  assign w_stall   = IDout_Valid && IDout_MemRead && (IDout_Rt != 5'd0) &&
                     ((IDout_Rt == w_rs) || ((IDout_Rt == w_rt) && w_uses_rt));
  assign w_bubble  = MEM_PCSrc || w_stall;
  assign IF_EN     = MEM_PCSrc || !w_stall;

  // Register file storage; register 0 is never written
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (WB_RegWrite && (WB_Rd != 5'd0)) begin
      r_regs[WB_Rd] <= WB_Data;
    end
  end

  // ID/EX pipeline register; bubbles clear Valid and every control bit
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      IDout_Valid    <= 1'b0;
      IDout_PC4      <= RESET_PC4;
      IDout_A        <= 32'd0;
      IDout_B        <= 32'd0;
      IDout_Imm      <= 32'd0;
      IDout_Jtarg    <= 32'd0;
      IDout_Rs       <= 5'd0;
      IDout_Rt       <= 5'd0;
      IDout_Rd       <= 5'd0;
      IDout_RegWrite <= 1'b0;
      IDout_MemtoReg <= 1'b0;
      IDout_MemRead  <= 1'b0;
      IDout_MemWrite <= 1'b0;
      IDout_Branch   <= 1'b0;
      IDout_Jump     <= 1'b0;
      IDout_ALUSrc   <= 1'b0;
      IDout_RegDst   <= 1'b0;
      IDout_ALUCtrl  <= ALU_ADD;
    end else begin
      IDout_PC4   <= IFout_PC4;
      IDout_A     <= w_a;
      IDout_B     <= w_b;
      IDout_Imm   <= {{16{IFout_Inst[15]}}, IFout_Inst[15:0]};
      IDout_Jtarg <= {IFout_PC4[31:28], IFout_Inst[25:0], 2'b00};
      IDout_Rs    <= w_rs;
      IDout_Rt    <= w_rt;
      IDout_Rd    <= IFout_Inst[15:11];
      if (w_bubble) begin
        IDout_Valid    <= 1'b0;
        IDout_RegWrite <= 1'b0;
        IDout_MemtoReg <= 1'b0;
        IDout_MemRead  <= 1'b0;
        IDout_MemWrite <= 1'b0;
        IDout_Branch   <= 1'b0;
        IDout_Jump     <= 1'b0;
        IDout_ALUSrc   <= 1'b0;
        IDout_RegDst   <= 1'b0;
        IDout_ALUCtrl  <= ALU_ADD;
      end else begin
        IDout_Valid    <= 1'b1;
        IDout_RegWrite <= w_regwrite;
        IDout_MemtoReg <= w_memtoreg;
        IDout_MemRead  <= w_memread;
        IDout_MemWrite <= w_memwrite;
        IDout_Branch   <= w_branch;
        IDout_Jump     <= w_jump;
        IDout_ALUSrc   <= w_alusrc;
        IDout_RegDst   <= w_regdst;
        IDout_ALUCtrl  <= w_aluctrl;
      end
    end
  end

endmodule

// File: tb/tb_stage_id.sv
// Scoreboard bench for stage_id: a reference model predicts each ID/EX result,
// a separate monitor compares it one edge later.
module tb_stage_id;
  localparam logic [31:0] RST_PC4 = 32'h0000_0BC4;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic [31:0] IFout_PC4, IFout_Inst, WB_Data;
  logic        MEM_PCSrc, WB_RegWrite;
  logic [4:0]  WB_Rd;
  logic        IF_EN, IDout_Valid;
  logic [31:0] IDout_PC4, IDout_A, IDout_B, IDout_Imm, IDout_Jtarg;
  logic [4:0]  IDout_Rs, IDout_Rt, IDout_Rd;
  logic        IDout_RegWrite, IDout_MemtoReg, IDout_MemRead, IDout_MemWrite;
  logic        IDout_Branch, IDout_Jump, IDout_ALUSrc, IDout_RegDst;
  logic [2:0]  IDout_ALUCtrl;

  stage_id #(.RESET_PC4(RST_PC4)) dut (
    .Clk(Clk), .Clrn(Clrn), .IFout_PC4(IFout_PC4), .IFout_Inst(IFout_Inst),
    .MEM_PCSrc(MEM_PCSrc), .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
    .IF_EN(IF_EN), .IDout_Valid(IDout_Valid), .IDout_PC4(IDout_PC4),
    .IDout_A(IDout_A), .IDout_B(IDout_B), .IDout_Imm(IDout_Imm), .IDout_Jtarg(IDout_Jtarg),
    .IDout_Rs(IDout_Rs), .IDout_Rt(IDout_Rt), .IDout_Rd(IDout_Rd),
    .IDout_RegWrite(IDout_RegWrite), .IDout_MemtoReg(IDout_MemtoReg),
    .IDout_MemRead(IDout_MemRead), .IDout_MemWrite(IDout_MemWrite),
    .IDout_Branch(IDout_Branch), .IDout_Jump(IDout_Jump), .IDout_ALUSrc(IDout_ALUSrc),
    .IDout_RegDst(IDout_RegDst), .IDout_ALUCtrl(IDout_ALUCtrl)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        valid;
    logic        rw, mtr, mr, mw, br, jp, as, rd;
    logic [2:0]  alu;
    logic [31:0] pc4, a, b, imm, jt;
    logic [4:0]  rs, rt, rdn;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_regs [32];
  logic        m_valid, m_memread;
  logic [4:0]  m_rt;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] rtype(int rs, int rt, int rd, logic [5:0] f);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] rd_model(logic [4:0] r, logic we, logic [4:0] wrd, logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wrd == r) return wd;
    return m_regs[r];
  endfunction

  // Behavioural instruction semantics: what each mnemonic asks of the later stages
  function automatic exp_t model(logic [31:0] inst, logic [31:0] pc4, logic [31:0] a, logic [31:0] b);
    exp_t e = '0;
    logic [5:0] op = inst[31:26];
    logic [5:0] f  = inst[5:0];
    e.valid = 1'b1; e.alu = 3'b010;
    e.pc4 = pc4; e.a = a; e.b = b;
    e.imm = 32'($signed(inst[15:0]));
    e.jt  = {pc4[31:28], 28'(inst[25:0]) << 2};
    e.rs = inst[25:21]; e.rt = inst[20:16]; e.rdn = inst[15:11];
    if (op == 6'h00) begin
      if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A) begin
        e.rw = 1'b1; e.rd = 1'b1;
        e.alu = (f == 6'h20) ? 3'b010 : (f == 6'h22) ? 3'b110 :
                (f == 6'h24) ? 3'b000 : (f == 6'h25) ? 3'b001 : 3'b111;
      end
    end else if (op == 6'h23) begin e.rw = 1'b1; e.mtr = 1'b1; e.mr = 1'b1; e.as = 1'b1; end
    else if (op == 6'h2B) begin e.mw = 1'b1; e.as = 1'b1; end
    else if (op == 6'h04) begin e.br = 1'b1; e.alu = 3'b110; end
    else if (op == 6'h08) begin e.rw = 1'b1; e.as = 1'b1; end
    else if (op == 6'h02) e.jp = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [5:0] fs [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    int k = $urandom_range(0, 9);
    int rs = $urandom_range(0, 7), rt = $urandom_range(0, 7), rd = $urandom_range(0, 7);
    logic [15:0] imm = 16'($urandom);
    case (k)
      0, 1, 2: begin
        logic [5:0] f = fs[$urandom_range(0, 5)];
        if (f == 6'h00) f = 6'($urandom);
        return rtype(rs, rt, rd, f);
      end
      3, 4: return itype(6'h23, rs, rt, imm);
      5:    return itype(6'h2B, rs, rt, imm);
      6:    return itype(6'h04, rs, rt, imm);
      7:    return itype(6'h08, rs, rt, imm);
      8:    return {6'h02, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  // Present one fetch word, predict the outcome, push it and check IF_EN
  task automatic step(input logic [31:0] inst, input logic [31:0] pc4, input logic pcsrc,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                      output logic en);
    exp_t e;
    logic st, uses_rt;
    @(negedge Clk);
    IFout_Inst = inst; IFout_PC4 = pc4; MEM_PCSrc = pcsrc;
    WB_RegWrite = we; WB_Rd = wrd; WB_Data = wd;
    uses_rt = (inst[31:26] == 6'h00) || (inst[31:26] == 6'h2B) || (inst[31:26] == 6'h04);
    st = m_valid && m_memread && (m_rt != 5'd0) &&
         ((m_rt == inst[25:21]) || ((m_rt == inst[20:16]) && uses_rt));
    en = pcsrc || !st;
    e = model(inst, pc4, rd_model(inst[25:21], we, wrd, wd), rd_model(inst[20:16], we, wrd, wd));
    if (pcsrc || st) begin
      e.valid = 1'b0; e.rw = 1'b0; e.mtr = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
      e.br = 1'b0; e.jp = 1'b0; e.as = 1'b0; e.rd = 1'b0;
    end
    sb.push_back(e);
    #1 chk("if_en", 32'(IF_EN), 32'(en));
    if (we && wrd != 5'd0) m_regs[wrd] = wd;
    m_valid = e.valid; m_memread = e.mr; m_rt = e.rt;
  endtask

  // Monitor: compare the ID/EX register against the oldest prediction
  exp_t me;
  always @(posedge Clk) begin
    #1;
    if (Clrn && sb.size() > 0) begin
      me = sb.pop_front();
      chk("valid",    32'(IDout_Valid),    32'(me.valid));
      chk("regwrite", 32'(IDout_RegWrite), 32'(me.rw));
      chk("memtoreg", 32'(IDout_MemtoReg), 32'(me.mtr));
      chk("memread",  32'(IDout_MemRead),  32'(me.mr));
      chk("memwrite", 32'(IDout_MemWrite), 32'(me.mw));
      chk("branch",   32'(IDout_Branch),   32'(me.br));
      chk("jump",     32'(IDout_Jump),     32'(me.jp));
      chk("alusrc",   32'(IDout_ALUSrc),   32'(me.as));
      chk("regdst",   32'(IDout_RegDst),   32'(me.rd));
      if (me.valid) begin
        chk("aluctrl", 32'(IDout_ALUCtrl), 32'(me.alu));
        chk("pc4",     IDout_PC4,   me.pc4);
        chk("a",       IDout_A,     me.a);
        chk("b",       IDout_B,     me.b);
        chk("imm",     IDout_Imm,   me.imm);
        chk("jtarg",   IDout_Jtarg, me.jt);
        chk("rs",      32'(IDout_Rs), 32'(me.rs));
        chk("rt",      32'(IDout_Rt), 32'(me.rt));
        chk("rd",      32'(IDout_Rd), 32'(me.rdn));
      end
    end
  end

  task automatic check_reset_state(string tag);
    chk({tag, "_valid"},   32'(IDout_Valid),   32'd0);
    chk({tag, "_pc4"},     IDout_PC4,          RST_PC4);
    chk({tag, "_aluctrl"}, 32'(IDout_ALUCtrl), 32'd2);
    chk({tag, "_a"},       IDout_A,            32'd0);
    chk({tag, "_ctl"}, 32'({IDout_RegWrite, IDout_MemtoReg, IDout_MemRead, IDout_MemWrite,
                            IDout_Branch, IDout_Jump, IDout_ALUSrc, IDout_RegDst}), 32'd0);
    chk({tag, "_if_en"},   32'(IF_EN),         32'd1);
  endtask

  logic [31:0] cur, pc;
  logic        en, pcs;
  logic [31:0] lw2, add3;

  initial begin
    Clrn = 1'b0; IFout_PC4 = 32'd0; IFout_Inst = 32'd0; MEM_PCSrc = 1'b0;
    WB_RegWrite = 1'b0; WB_Rd = 5'd0; WB_Data = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0; m_memread = 1'b0; m_rt = 5'd0;
    #12 check_reset_state("reset");
    @(negedge Clk) Clrn = 1'b1;

    lw2  = itype(6'h23, 1, 2, 16'h0008);
    add3 = rtype(2, 4, 3, 6'h20);
    step(32'd0, 32'h100, 1'b0, 1'b1, 5'd9,  32'd5, en);
    step(32'd0, 32'h104, 1'b0, 1'b1, 5'd10, 32'd7, en);
    step(32'h012A4020, 32'h108, 1'b0, 1'b0, 5'd0, 32'd0, en);
    step(lw2,  32'h10C, 1'b0, 1'b0, 5'd0, 32'd0, en);
    step(add3, 32'h110, 1'b0, 1'b0, 5'd0, 32'd0, en);
    step(add3, 32'h110, 1'b0, 1'b0, 5'd0, 32'd0, en);
    step(lw2,  32'h114, 1'b0, 1'b0, 5'd0, 32'd0, en);
    step(itype(6'h08, 0, 2, 16'h0001), 32'h118, 1'b0, 1'b0, 5'd0, 32'd0, en);
    step(lw2,  32'h11C, 1'b0, 1'b0, 5'd0, 32'd0, en);
    step(add3, 32'h120, 1'b1, 1'b0, 5'd0, 32'd0, en);
    step(32'd0, 32'h200, 1'b0, 1'b0, 5'd0, 32'd0, en);
    step(rtype(5, 0, 1, 6'h20), 32'h204, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, en);
    step(rtype(0, 0, 1, 6'h20), 32'h208, 1'b0, 1'b1, 5'd0, 32'h1234_5678, en);
    step(itype(6'h04, 1, 2, 16'hFFFC), 32'h20C, 1'b0, 1'b0, 5'd0, 32'd0, en);
    step({6'h02, 26'h0100000}, 32'h40000004, 1'b0, 1'b0, 5'd0, 32'd0, en);

    cur = rand_inst(); pc = 32'h1000;
    repeat (400) begin
      pcs = ($urandom_range(0, 9) == 0);
      step(cur, pc, pcs, 1'($urandom), 5'($urandom_range(0, 7)), $urandom, en);
      if (en) begin
        cur = rand_inst();
        pc  = pcs ? (($urandom & 32'hFFFF_FFFC) + 32'd4) : pc + 32'd4;
      end
    end

    // Reset asserted in the middle of a load-use stall
    step(32'd0, 32'h300, 1'b0, 1'b0, 5'd0, 32'd0, en);
    step(32'd0, 32'h304, 1'b0, 1'b0, 5'd0, 32'd0, en);
    step(lw2,   32'h308, 1'b0, 1'b0, 5'd0, 32'd0, en);
    @(negedge Clk);
    IFout_Inst = add3; IFout_PC4 = 32'h30C; MEM_PCSrc = 1'b0; WB_RegWrite = 1'b0;
    #1 chk("stall_if_en", 32'(IF_EN), 32'd0);
    Clrn = 1'b0;
    #1 check_reset_state("midstall");
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0; m_memread = 1'b0; m_rt = 5'd0;
    @(negedge Clk) Clrn = 1'b1;
    step(32'h012A4020, 32'h400, 1'b0, 1'b0, 5'd0, 32'd0, en);
    @(posedge Clk);
    #3 chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
